// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of the hazard-control signals between the pipeline (master) and hazard_stall_ctrl (slave).
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             branch_taken;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             ctrl_bubble;
    logic             stalling;
    logic [CNT_W-1:0] stall_total;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken,
        input  pc_write, ifid_write, ifid_flush, ctrl_bubble, stalling, stall_total
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken,
        output pc_write, ifid_write, ifid_flush, ctrl_bubble, stalling, stall_total
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard stall and branch flush control for the 5-stage pipeline,
// with a saturating stall-cycle performance counter.
module hazard_stall_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input logic                clk,
    input logic                rst_n,
    hazard_stall_ctrl_if.slave bus
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;
    localparam logic [3:0] REM_INIT = 4'(STALL_CYCLES - 1);

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic [3:0]       rem_r;
    logic [3:0]       rem_nxt_s;
    logic [CNT_W-1:0] stall_total_r;
    logic             hazard_s;
    logic             pc_write_s;
    logic             ifid_write_s;
    logic             ifid_flush_s;
    logic             ctrl_bubble_s;
    logic             stalling_s;

    // Load in EX writes a register that the ID instruction reads (r0 never hazards).
    always_comb begin
        hazard_s = bus.id_valid & bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                   ((bus.ex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));
    end

    // Control outputs: reset forces RUN defaults, then branch flush, then stall.
    always_comb begin
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        ctrl_bubble_s = 1'b0;
        stalling_s    = 1'b0;
        if (!rst_n) begin
            pc_write_s = 1'b1;
        end else if (bus.branch_taken) begin
            ifid_flush_s  = 1'b1;
            ctrl_bubble_s = 1'b1;
        end else if ((state_r == ST_STALL) || hazard_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            ctrl_bubble_s = 1'b1;
            stalling_s    = 1'b1;
        end else begin
            pc_write_s = 1'b1;
        end
    end

    // Next state: the hazard cycle itself is stall cycle 1, STALL covers the remaining ones.
    always_comb begin
        state_nxt_s = ST_RUN;
        rem_nxt_s   = 4'd0;
        if (bus.branch_taken) begin
            state_nxt_s = ST_RUN;
            rem_nxt_s   = 4'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (hazard_s && (REM_INIT != 4'd0)) begin
                        state_nxt_s = ST_STALL;
                        rem_nxt_s   = REM_INIT;
                    end else begin
                        state_nxt_s = ST_RUN;
                        rem_nxt_s   = 4'd0;
                    end
                end
                ST_STALL: begin
                    if (rem_r <= 4'd1) begin
                        state_nxt_s = ST_RUN;
                        rem_nxt_s   = 4'd0;
                    end else begin
                        state_nxt_s = ST_STALL;
                        rem_nxt_s   = rem_r - 4'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    rem_nxt_s   = 4'd0;
                end
            endcase
        end
    end

    // State, remaining-cycle counter and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            rem_r         <= 4'd0;
            stall_total_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            rem_r   <= rem_nxt_s;
            if (stalling_s && (stall_total_r != {CNT_W{1'b1}})) begin
                stall_total_r <= stall_total_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_total_r <= stall_total_r;
            end
        end
    end

    assign bus.pc_write    = pc_write_s;
    assign bus.ifid_write  = ifid_write_s;
    assign bus.ifid_flush  = ifid_flush_s;
    assign bus.ctrl_bubble = ctrl_bubble_s;
    assign bus.stalling    = stalling_s;
    assign bus.stall_total = stall_total_r;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Drives a 3-cycle/32-bit and a 1-cycle/4-bit hazard_stall_ctrl with the same stimulus
// and checks both against a cycle-level model plus hand-computed expectations.
module tb_hazard_stall_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rt, ex_mem_read, branch_taken;
    logic [4:0] id_rs, id_rt, ex_rt;
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         chk_en  = 1'b0;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(32)) ifa ();
    hazard_stall_ctrl_if #(.CNT_W(4))  ifb ();

    assign ifa.id_valid = id_valid;     assign ifb.id_valid = id_valid;
    assign ifa.id_rs = id_rs;           assign ifb.id_rs = id_rs;
    assign ifa.id_rt = id_rt;           assign ifb.id_rt = id_rt;
    assign ifa.id_uses_rt = id_uses_rt; assign ifb.id_uses_rt = id_uses_rt;
    assign ifa.ex_mem_read = ex_mem_read; assign ifb.ex_mem_read = ex_mem_read;
    assign ifa.ex_rt = ex_rt;           assign ifb.ex_rt = ex_rt;
    assign ifa.branch_taken = branch_taken; assign ifb.branch_taken = branch_taken;

    hazard_stall_ctrl #(.STALL_CYCLES(3), .CNT_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    hazard_stall_ctrl #(.STALL_CYCLES(1), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outstanding stall cycles and stall count per instance.
    int     m_left [2];
    longint m_total[2];
    int     m_cyc  [2] = '{3, 1};
    longint m_max  [2] = '{64'hFFFF_FFFF, 64'd15};

    always @(negedge clk) begin
        if (chk_en) begin
            bit         haz;
            logic [4:0] exp_v, act_v;
            longint     act_t;
            haz = id_valid && ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin
                    act_v = {ifa.pc_write, ifa.ifid_write, ifa.ifid_flush, ifa.ctrl_bubble, ifa.stalling};
                    act_t = longint'(ifa.stall_total);
                end else begin
                    act_v = {ifb.pc_write, ifb.ifid_write, ifb.ifid_flush, ifb.ctrl_bubble, ifb.stalling};
                    act_t = longint'(ifb.stall_total);
                end
                check($sformatf("model_total[%0d]", i), act_t, m_total[i]);
                if (!rst_n) begin
                    exp_v = 5'b11000;
                    m_left[i] = 0;
                    m_total[i] = 0;
                end else if (branch_taken) begin
                    exp_v = 5'b11110;
                    m_left[i] = 0;
                end else if ((m_left[i] > 0) || haz) begin
                    exp_v = 5'b00011;
                    m_left[i] = (m_left[i] > 0) ? m_left[i] - 1 : m_cyc[i] - 1;
                    if (m_total[i] < m_max[i]) m_total[i] = m_total[i] + 1;
                end else begin
                    exp_v = 5'b11000;
                end
                check($sformatf("model_ctrl[%0d]", i), longint'(act_v), longint'(exp_v));
            end
        end
    end

    task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic use_rt, input logic mr, input logic [4:0] ert, input logic br);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = use_rt;
        ex_mem_read = mr; ex_rt = ert; branch_taken = br;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        m_left  = '{0, 0};
        m_total = '{0, 0};
        rst_n = 1'b0;
        idle();
        step();
        chk_en = 1'b1;
        step();
        check("reset_total_a", longint'(ifa.stall_total), 0);
        check("reset_total_b", longint'(ifb.stall_total), 0);
        check("reset_pc_a", longint'(ifa.pc_write), 1);
        rst_n = 1'b1;
        step();

        // load into r8 read as rs
        set_in(1'b1, 5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0);
        check("t1_pc_a", longint'(ifa.pc_write), 0);
        check("t1_pc_b", longint'(ifb.pc_write), 0);
        check("t1_bubble_b", longint'(ifb.ctrl_bubble), 1);
        step();
        idle();
        check("t1_stall2_a", longint'(ifa.stalling), 1);
        check("t1_run_b", longint'(ifb.stalling), 0);
        check("t1_total_b", longint'(ifb.stall_total), 1);
        step();
        step();
        check("t1_end_pc_a", longint'(ifa.pc_write), 1);
        check("t1_total_a", longint'(ifa.stall_total), 3);

        // r0, rt unused, and invalid ID never stall
        set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        check("t2_r0_a", longint'(ifa.stalling), 0);
        check("t2_r0_pc_b", longint'(ifb.pc_write), 1);
        step();
        set_in(1'b1, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0);
        check("t2_imm_a", longint'(ifa.stalling), 0);
        check("t2_imm_b", longint'(ifb.stalling), 0);
        step();
        set_in(1'b0, 5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0);
        check("t2_inval_b", longint'(ifb.stalling), 0);
        step();

        // rt hazard with id_uses_rt: exactly 3 stall cycles on A
        set_in(1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
        check("t3_c1_a", longint'(ifa.stalling), 1);
        step();
        idle();
        check("t3_c2_a", longint'(ifa.stalling), 1);
        step();
        check("t3_c3_a", longint'(ifa.stalling), 1);
        step();
        check("t3_c4_a", longint'(ifa.stalling), 0);
        check("t3_pc_a", longint'(ifa.pc_write), 1);
        check("t3_total_a", longint'(ifa.stall_total), 6);

        // branch in 2nd stall cycle
        set_in(1'b1, 5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0);
        step();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        check("t4_flush_a", longint'(ifa.ifid_flush), 1);
        check("t4_bubble_a", longint'(ifa.ctrl_bubble), 1);
        check("t4_pc_a", longint'(ifa.pc_write), 1);
        check("t4_stall_a", longint'(ifa.stalling), 0);
        step();
        idle();
        check("t4_after_a", longint'(ifa.stalling), 0);
        check("t4_total_a", longint'(ifa.stall_total), 7);
        check("t4_total_b", longint'(ifb.stall_total), 3);

        // reset in 2nd stall cycle
        set_in(1'b1, 5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0);
        step();
        idle();
        rst_n = 1'b0;
        #1;
        check("t5_pc_a", longint'(ifa.pc_write), 1);
        check("t5_stall_a", longint'(ifa.stalling), 0);
        check("t5_bubble_a", longint'(ifa.ctrl_bubble), 0);
        step();
        check("t5_total_a", longint'(ifa.stall_total), 0);
        check("t5_total_b", longint'(ifb.stall_total), 0);
        rst_n = 1'b1;
        step();
        check("t5_release_a", longint'(ifa.stalling), 0);

        // continuous hazard: back-to-back stalls on A, saturation on 4-bit B
        set_in(1'b1, 5'd7, 5'd1, 1'b0, 1'b1, 5'd7, 1'b0);
        repeat (17) step();
        idle();
        check("t6_sat_b", longint'(ifb.stall_total), 15);
        check("t6_total_a", longint'(ifa.stall_total), 17);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
